// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch, PC update, decode,
// execute, memory and writeback, and drives the PC load strobe.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       write_pc,
    output logic [1:0] pcsource,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       aluout_we,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_PCU = 4'd1,
        S_ID  = 4'd2,
        S_EXR = 4'd3,
        S_WBR = 4'd4,
        S_EXI = 4'd5,
        S_WBI = 4'd6,
        S_MA  = 4'd7,
        S_MRD = 4'd8,
        S_WBM = 4'd9,
        S_MWR = 4'd10,
        S_BR  = 4'd11,
        S_BRU = 4'd12,
        S_JMP = 4'd13
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   write_pc_q;
    logic   write_pc_d;
    logic   funct_ok;

    // Recognised R-type function codes; anything else aborts to fetch.
    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    end

    // Next-state and datapath controls decoded from the current state.
    always_comb begin
        state_d    = S_IF;
        pcsource   = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        aluout_we  = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                state_d   = S_PCU;
            end
            S_PCU: begin
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                state_d   = S_ID;
            end
            S_ID: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                aluout_we = 1'b1;
                if (opcode == OP_J) pcsource = 2'b10;
                case (opcode)
                    OP_RTYPE:     state_d = funct_ok ? S_EXR : S_IF;
                    OP_ADDI:      state_d = S_EXI;
                    OP_LW, OP_SW: state_d = S_MA;
                    OP_BEQ,
                    OP_BNE:       state_d = S_BR;
                    OP_J:         state_d = S_JMP;
                    default:      state_d = S_IF;
                endcase
            end
            S_EXR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                aluout_we = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_d = S_WBR;
            end
            S_WBR: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_IF;
            end
            S_EXI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                aluout_we = 1'b1;
                state_d   = S_WBI;
            end
            S_WBI: begin
                reg_write = 1'b1;
                state_d   = S_IF;
            end
            S_MA: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                aluout_we = 1'b1;
                state_d   = (opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_WBM;
            end
            S_WBM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_IF;
            end
            S_MWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = S_IF;
            end
            S_BR: begin
                // ALUOut keeps the branch target computed in decode.
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_ctrl  = ALU_SUB;
                pcsource  = 2'b01;
                if (((opcode == OP_BEQ) && zero) ||
                    ((opcode == OP_BNE) && !zero))
                    state_d = S_BRU;
                else
                    state_d = S_IF;
            end
            S_BRU: begin
                pcsource = 2'b01;
                state_d  = S_IF;
            end
            S_JMP: begin
                pcsource = 2'b10;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // PC strobe is registered so it is glitch-free; it rises on entry
    // to the states that update the PC.
    always_comb begin
        write_pc_d = 1'b0;
        if (!rst) begin
            write_pc_d = (state_d == S_PCU) ||
                         (state_d == S_BRU) ||
                         (state_d == S_JMP);
        end
    end

    // State and strobe registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IF;
            write_pc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_pc_q <= write_pc_d;
        end
    end

    assign write_pc = write_pc_q;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through
// its state sequence and checks strobes against hand-derived values.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       write_pc;
    logic [1:0] pcsource;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       aluout_we;
    logic [3:0] state;

    int n_cmp;
    int n_bad;

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .write_pc   (write_pc),
        .pcsource   (pcsource),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .aluout_we  (aluout_we),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check the state reached.
    task automatic step(input string tag, input logic [3:0] exp_st);
        @(posedge clk);
        #1;
        chk(tag, {4'd0, state}, {4'd0, exp_st});
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        opcode = 6'h00;
        funct  = 6'h20;
        zero   = 1'b0;

        // Reset for two cycles
        @(posedge clk); #1;
        chk("rst_st1", {4'd0, state}, 8'd0);
        chk("rst_wpc1", {7'd0, write_pc}, 8'd0);
        @(posedge clk); #1;
        chk("rst_st2", {4'd0, state}, 8'd0);
        chk("rst_wpc2", {7'd0, write_pc}, 8'd0);
        rst = 1'b0;
        chk("if_mrd", {7'd0, mem_read}, 8'd1);
        chk("if_irw", {7'd0, ir_write}, 8'd1);
        chk("if_srcb", {6'd0, alu_src_b}, 8'd1);
        chk("if_wpc", {7'd0, write_pc}, 8'd0);

        // R-type add
        step("r_pcu", 4'd1);
        chk("r_pcu_wpc", {7'd0, write_pc}, 8'd1);
        chk("r_pcu_pcs", {6'd0, pcsource}, 8'd0);
        step("r_id", 4'd2);
        chk("r_id_wpc", {7'd0, write_pc}, 8'd0);
        chk("r_id_srcb", {6'd0, alu_src_b}, 8'd3);
        chk("r_id_awe", {7'd0, aluout_we}, 8'd1);
        step("r_exr", 4'd3);
        chk("r_exr_alu", {5'd0, alu_ctrl}, 8'h02);
        chk("r_exr_srca", {7'd0, alu_src_a}, 8'd1);
        chk("r_exr_rw", {7'd0, reg_write}, 8'd0);
        step("r_wbr", 4'd4);
        chk("r_wbr_rw", {7'd0, reg_write}, 8'd1);
        chk("r_wbr_dst", {7'd0, reg_dst}, 8'd1);
        chk("r_wbr_m2r", {7'd0, mem_to_reg}, 8'd0);
        step("r_if", 4'd0);

        // R-type slt
        funct = 6'h2A;
        step("slt_pcu", 4'd1);
        step("slt_id", 4'd2);
        step("slt_exr", 4'd3);
        chk("slt_alu", {5'd0, alu_ctrl}, 8'h07);
        step("slt_wbr", 4'd4);
        step("slt_if", 4'd0);

        // R-type with unknown funct aborts after decode
        funct = 6'h3F;
        step("badf_pcu", 4'd1);
        step("badf_id", 4'd2);
        step("badf_if", 4'd0);
        chk("badf_rw", {7'd0, reg_write}, 8'd0);

        // ADDI
        opcode = 6'h08;
        funct  = 6'h20;
        step("ai_pcu", 4'd1);
        step("ai_id", 4'd2);
        step("ai_exi", 4'd5);
        chk("ai_srcb", {6'd0, alu_src_b}, 8'd2);
        step("ai_wbi", 4'd6);
        chk("ai_rw", {7'd0, reg_write}, 8'd1);
        chk("ai_dst", {7'd0, reg_dst}, 8'd0);
        step("ai_if", 4'd0);

        // LW
        opcode = 6'h23;
        step("lw_pcu", 4'd1);
        step("lw_id", 4'd2);
        step("lw_ma", 4'd7);
        chk("lw_ma_srcb", {6'd0, alu_src_b}, 8'd2);
        chk("lw_ma_awe", {7'd0, aluout_we}, 8'd1);
        step("lw_mrd", 4'd8);
        chk("lw_mrd_rd", {7'd0, mem_read}, 8'd1);
        chk("lw_mrd_iord", {7'd0, iord}, 8'd1);
        step("lw_wbm", 4'd9);
        chk("lw_wbm_m2r", {7'd0, mem_to_reg}, 8'd1);
        chk("lw_wbm_rw", {7'd0, reg_write}, 8'd1);
        chk("lw_wbm_dst", {7'd0, reg_dst}, 8'd0);
        step("lw_if", 4'd0);

        // SW
        opcode = 6'h2B;
        step("sw_pcu", 4'd1);
        step("sw_id", 4'd2);
        step("sw_ma", 4'd7);
        step("sw_mwr", 4'd10);
        chk("sw_mw", {7'd0, mem_write}, 8'd1);
        chk("sw_iord", {7'd0, iord}, 8'd1);
        chk("sw_rw", {7'd0, reg_write}, 8'd0);
        step("sw_if", 4'd0);

        // BEQ taken
        opcode = 6'h04;
        step("beq1_pcu", 4'd1);
        step("beq1_id", 4'd2);
        step("beq1_br", 4'd11);
        zero = 1'b1;
        #1;
        chk("beq1_awe", {7'd0, aluout_we}, 8'd0);
        chk("beq1_pcs", {6'd0, pcsource}, 8'd1);
        chk("beq1_alu", {5'd0, alu_ctrl}, 8'h06);
        chk("beq1_wpc0", {7'd0, write_pc}, 8'd0);
        step("beq1_bru", 4'd12);
        chk("beq1_wpc", {7'd0, write_pc}, 8'd1);
        chk("beq1_pcs2", {6'd0, pcsource}, 8'd1);
        step("beq1_if", 4'd0);
        chk("beq1_wpc2", {7'd0, write_pc}, 8'd0);

        // BEQ not taken
        zero = 1'b0;
        step("beq0_pcu", 4'd1);
        step("beq0_id", 4'd2);
        step("beq0_br", 4'd11);
        step("beq0_if", 4'd0);
        chk("beq0_wpc", {7'd0, write_pc}, 8'd0);

        // BNE taken on zero=0, not taken on zero=1
        opcode = 6'h05;
        step("bne0_pcu", 4'd1);
        step("bne0_id", 4'd2);
        step("bne0_br", 4'd11);
        step("bne0_bru", 4'd12);
        chk("bne0_wpc", {7'd0, write_pc}, 8'd1);
        step("bne0_if", 4'd0);
        step("bne1_pcu", 4'd1);
        step("bne1_id", 4'd2);
        step("bne1_br", 4'd11);
        zero = 1'b1;
        step("bne1_if", 4'd0);
        chk("bne1_wpc", {7'd0, write_pc}, 8'd0);
        zero = 1'b0;

        // Jump
        opcode = 6'h02;
        step("j_pcu", 4'd1);
        step("j_id", 4'd2);
        chk("j_id_pcs", {6'd0, pcsource}, 8'd2);
        chk("j_id_wpc", {7'd0, write_pc}, 8'd0);
        step("j_jmp", 4'd13);
        chk("j_jmp_pcs", {6'd0, pcsource}, 8'd2);
        chk("j_jmp_wpc", {7'd0, write_pc}, 8'd1);
        step("j_if", 4'd0);
        chk("j_if_wpc", {7'd0, write_pc}, 8'd0);

        // Illegal opcode: three cycles, no writes
        opcode = 6'h3F;
        step("ill_pcu", 4'd1);
        step("ill_id", 4'd2);
        chk("ill_rw", {7'd0, reg_write}, 8'd0);
        chk("ill_mw", {7'd0, mem_write}, 8'd0);
        step("ill_if", 4'd0);

        // Reset during EXR
        opcode = 6'h00;
        funct  = 6'h20;
        step("rx_pcu", 4'd1);
        step("rx_id", 4'd2);
        step("rx_exr", 4'd3);
        rst = 1'b1;
        step("rx_if", 4'd0);
        chk("rx_wpc", {7'd0, write_pc}, 8'd0);
        chk("rx_rw", {7'd0, reg_write}, 8'd0);
        rst = 1'b0;

        // Reset during a taken BEQ
        opcode = 6'h04;
        step("rb_pcu", 4'd1);
        step("rb_id", 4'd2);
        step("rb_br", 4'd11);
        zero = 1'b1;
        rst  = 1'b1;
        step("rb_if", 4'd0);
        chk("rb_wpc", {7'd0, write_pc}, 8'd0);
        rst  = 1'b0;
        zero = 1'b0;
        step("rb_pcu2", 4'd1);
        chk("rb_wpc2", {7'd0, write_pc}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
